// File: rtl/imm_gen_pipe.sv
// Registered RV32I immediate generator (I/S/B/U/J) behind a valid/ready handshake with a 2-entry output buffer.
// Define IMM_GEN_OPDEC_EN to remove in_src and decode the format from the opcode in in_instr[6:0].
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
`ifndef IMM_GEN_OPDEC_EN
   input  logic [2:0]       in_src,
`endif
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      FMT_I   = 3'd0,
      FMT_S   = 3'd1,
      FMT_B   = 3'd2,
      FMT_U   = 3'd3,
      FMT_J   = 3'd4,
      FMT_BAD = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             err;
   } entry_t;

   fmt_e        w_fmt;
   logic [31:0] w_imm32;
   logic        w_err;
   entry_t      w_new;
   logic        w_push;
   logic        w_pop;

   entry_t         r_head;
   entry_t         r_tail;
   logic [1:0]     r_cnt;
   logic [CNT_W-1:0] r_err_cnt;

`ifdef IMM_GEN_OPDEC_EN
   always_comb begin
      w_fmt = FMT_BAD;
      case (in_instr[6:0])
         7'b0010011, 7'b0000011,
         7'b1100111, 7'b1110011: w_fmt = FMT_I;
         7'b0100011:             w_fmt = FMT_S;
         7'b1100011:             w_fmt = FMT_B;
         7'b0110111, 7'b0010111: w_fmt = FMT_U;
         7'b1101111:             w_fmt = FMT_J;
         default:                w_fmt = FMT_BAD;
      endcase
   end
`else
   logic w_unused_opcode;
   assign w_unused_opcode = ^in_instr[6:0];

   always_comb begin
      w_fmt = FMT_BAD;
      case (in_src)
         3'd0:    w_fmt = FMT_I;
         3'd1:    w_fmt = FMT_S;
         3'd2:    w_fmt = FMT_B;
         3'd3:    w_fmt = FMT_U;
         3'd4:    w_fmt = FMT_J;
         default: w_fmt = FMT_BAD;
      endcase
   end
`endif

   // Every format is first built as a 32-bit sign-extended value, then widened to XLEN.
   always_comb begin
      w_imm32 = '0;
      w_err   = 1'b0;
      case (w_fmt)
         FMT_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U:   w_imm32 = {in_instr[31:12], 12'b0};
         FMT_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
         default: w_err   = 1'b1;
      endcase
   end

   assign w_new.imm = XLEN'($signed(w_imm32));
   assign w_new.tag = in_tag;
   assign w_new.err = w_err;

   // in_ready depends only on the registered count, never on out_ready.
   assign in_ready  = (r_cnt != 2'd2) && !rst;
   assign out_valid = (r_cnt != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   assign out_imm = r_head.imm;
   assign out_tag = r_head.tag;
   assign out_err = r_head.err;
   assign err_cnt = r_err_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= 2'd0;
         r_head    <= '0;
         r_tail    <= '0;
         r_err_cnt <= '0;
      end else begin
         if (w_push && w_new.err && (r_err_cnt != {CNT_W{1'b1}}))
            r_err_cnt <= r_err_cnt + CNT_W'(1);

         case (r_cnt)
            2'd0: begin
               if (w_push) begin
                  r_head <= w_new;
                  r_cnt  <= 2'd1;
               end
            end
            2'd1: begin
               case ({w_push, w_pop})
                  2'b11: r_head <= w_new;
                  2'b10: begin
                     r_tail <= w_new;
                     r_cnt  <= 2'd2;
                  end
                  2'b01: r_cnt <= 2'd0;
                  default: r_cnt <= 2'd1;
               endcase
            end
            2'd2: begin
               // Full: in_ready is low, so only a pop can happen here.
               if (w_pop) begin
                  r_head <= r_tail;
                  r_cnt  <= 2'd1;
               end
            end
            default: r_cnt <= 2'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/CNT_W=8 and a 64-bit/CNT_W=2 instance share all inputs
// and are checked against an arithmetic reference model with a queue standing in for the buffer.
module tb_imm_gen_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [2:0]  in_src;
   logic [4:0]  in_tag;
   logic        out_ready;

   logic        in_ready,  in_ready_b;
   logic        out_valid, out_valid_b;
   logic [31:0] out_imm;
   logic [63:0] out_imm_b;
   logic [4:0]  out_tag,   out_tag_b;
   logic        out_err,   out_err_b;
   logic [7:0]  err_cnt;
   logic [1:0]  err_cnt_b;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
`ifndef IMM_GEN_OPDEC_EN
      .in_src(in_src),
`endif
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_tag(out_tag), .out_err(out_err), .err_cnt(err_cnt)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(2)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
`ifndef IMM_GEN_OPDEC_EN
      .in_src(in_src),
`endif
      .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
      .out_tag(out_tag_b), .out_err(out_err_b), .err_cnt(err_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint     imm;
      logic [4:0] tag;
      bit         err;
   } ent_t;

   ent_t mq[$];
   int   mcnt;
   int   total;
   int   bad;

   function automatic int sat(int v, int m);
      return (v > m) ? m : v;
   endfunction

   // Reference: immediates built from field values with signed arithmetic on a 64-bit integer.
   function automatic ent_t ref_entry(logic [31:0] instr, logic [2:0] src, logic [4:0] tag);
      ent_t   e;
      int     f;
      longint s;
      longint sgn;
`ifdef IMM_GEN_OPDEC_EN
      case (instr[6:0])
         7'h13, 7'h03, 7'h67, 7'h73: f = 0;
         7'h23: f = 1;
         7'h63: f = 2;
         7'h37, 7'h17: f = 3;
         7'h6F: f = 4;
         default: f = 7;
      endcase
`else
      f = int'(src);
`endif
      s   = longint'($signed(instr));
      sgn = s >>> 31;
      e.tag = tag;
      e.err = 1'b0;
      case (f)
         0: e.imm = s >>> 20;
         1: e.imm = (s >>> 25) * 32 + longint'((instr >> 7) & 32'h1F);
         2: e.imm = sgn * 4096 + longint'((instr >> 7) & 32'h1) * 2048
                  + longint'((instr >> 25) & 32'h3F) * 32 + longint'((instr >> 8) & 32'hF) * 2;
         3: e.imm = (s >>> 12) * 4096;
         4: e.imm = sgn * 1048576 + longint'((instr >> 12) & 32'hFF) * 4096
                  + longint'((instr >> 20) & 32'h1) * 2048 + longint'((instr >> 21) & 32'h3FF) * 2;
         default: begin
            e.imm = 0;
            e.err = 1'b1;
         end
      endcase
      return e;
   endfunction

   // Advances one clock: inputs are set before, outputs are stable at the following negedge.
   task automatic tick();
      bit   m_rdy, m_pop, m_push;
      ent_t e;
      m_rdy  = (mq.size() != 2) && !rst;
      m_pop  = !rst && out_ready && (mq.size() != 0);
      m_push = in_valid && m_rdy;
      e      = ref_entry(in_instr, in_src, in_tag);
      @(posedge clk);
      if (rst) begin
         mq.delete();
         mcnt = 0;
      end else begin
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            mq.push_back(e);
            if (e.err) mcnt++;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_src = '0; in_tag = '0;
      @(negedge clk);
      tick();
      tick();
      total++; if (in_ready !== 1'b0 || in_ready_b !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b/%b exp=0", in_ready, in_ready_b); end
      total++; if (out_valid !== 1'b0 || out_valid_b !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b/%b exp=0", out_valid, out_valid_b); end
      total++; if (out_imm !== 32'h0 || out_imm_b !== 64'h0) begin bad++; $display("FAIL reset_out_imm got=%h/%h exp=0", out_imm, out_imm_b); end
      total++; if (out_tag !== 5'h0 || out_err !== 1'b0) begin bad++; $display("FAIL reset_tag_err got=%h/%b exp=0/0", out_tag, out_err); end
      total++; if (err_cnt !== 8'h0 || err_cnt_b !== 2'h0) begin bad++; $display("FAIL reset_err_cnt got=%h/%h exp=0", err_cnt, err_cnt_b); end
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1 || in_ready_b !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b/%b exp=1", in_ready, in_ready_b); end
   endtask

   task automatic test_formats();
      logic [2:0]  srcs [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
      logic [31:0] ins  [6] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h12345037, 32'h0000006F, 32'h80000037};
      logic [31:0] exps [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'h00000000, 32'h80000000};
      logic [63:0] exp64;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_src = srcs[i]; in_instr = ins[i]; in_tag = 5'(i);
         tick();
         exp64 = {{32{exps[i][31]}}, exps[i]};
         in_instr = $urandom; in_src = 3'($urandom);
         total++; if (out_valid !== 1'b1 || out_err !== 1'b0) begin bad++; $display("FAIL fmt%0d_valid_err got=%b/%b exp=1/0", i, out_valid, out_err); end
         total++; if (out_imm !== exps[i]) begin bad++; $display("FAIL fmt%0d_imm32 got=%h exp=%h", i, out_imm, exps[i]); end
         total++; if (out_imm_b !== exp64) begin bad++; $display("FAIL fmt%0d_imm64 got=%h exp=%h", i, out_imm_b, exp64); end
         total++; if (out_tag !== 5'(i)) begin bad++; $display("FAIL fmt%0d_tag got=%0d exp=%0d", i, out_tag, i); end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      logic [4:0] got[$];
      bit         sent3;
      out_ready = 1'b0; in_valid = 1'b1; in_src = 3'd0;
      in_tag = 5'd1; in_instr = $urandom;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
      tick();
      in_tag = 5'd2; in_instr = $urandom;
      total++; if (in_ready !== 1'b1 || out_tag !== 5'd1) begin bad++; $display("FAIL bp_ready2 got=%b/%0d exp=1/1", in_ready, out_tag); end
      tick();
      in_tag = 5'd3; in_instr = $urandom;
      total++; if (in_ready !== 1'b0 || in_ready_b !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b/%b exp=0", in_ready, in_ready_b); end
      tick();
      tick();
      total++; if (out_valid !== 1'b1 || out_tag !== 5'd1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold got=%b/%0d/%b exp=1/1/0", out_valid, out_tag, in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) got.push_back(out_tag);
         sent3 = in_valid && in_ready;
         tick();
         if (sent3) in_valid = 1'b0;
         if (got.size() == 3) break;
      end
      in_valid = 1'b0;
      total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
      for (int k = 0; k < got.size() && k < 3; k++) begin
         total++; if (got[k] !== 5'(k + 1)) begin bad++; $display("FAIL bp_order%0d got=%0d exp=%0d", k, got[k], k + 1); end
      end
      while (mq.size() != 0 && total < 100000) tick();
   endtask

   task automatic test_illegal();
      out_ready = 1'b1; in_valid = 1'b1; in_src = 3'd7;
      for (int i = 1; i <= 5; i++) begin
         in_instr = $urandom; in_tag = 5'(i);
         tick();
         total++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_err_b !== 1'b1) begin bad++; $display("FAIL ill%0d_err got=%b/%b exp=1", i, out_err, out_err_b); end
         total++; if (out_imm !== 32'h0 || out_imm_b !== 64'h0) begin bad++; $display("FAIL ill%0d_imm got=%h/%h exp=0", i, out_imm, out_imm_b); end
         if (i == 3) begin
            total++; if (err_cnt !== 8'd3 || err_cnt_b !== 2'd3) begin bad++; $display("FAIL ill_cnt3 got=%0d/%0d exp=3/3", err_cnt, err_cnt_b); end
         end
      end
      total++; if (err_cnt !== 8'd5) begin bad++; $display("FAIL ill_cnt5 got=%0d exp=5", err_cnt); end
      total++; if (err_cnt_b !== 2'd3) begin bad++; $display("FAIL ill_sat got=%0d exp=3", err_cnt_b); end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         total++; if (in_ready !== (mq.size() != 2) || in_ready_b !== (mq.size() != 2)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b/%b exp=%b", c, in_ready, in_ready_b, mq.size() != 2); end
         total++; if (out_valid !== (mq.size() != 0) || out_valid_b !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, mq.size() != 0); end
         if (mq.size() != 0) begin
            total++; if (out_imm !== mq[0].imm[31:0]) begin bad++; $display("FAIL rnd_imm32 c=%0d got=%h exp=%h", c, out_imm, mq[0].imm[31:0]); end
            total++; if (out_imm_b !== mq[0].imm) begin bad++; $display("FAIL rnd_imm64 c=%0d got=%h exp=%h", c, out_imm_b, mq[0].imm); end
            total++; if (out_tag !== mq[0].tag || out_err !== mq[0].err) begin bad++; $display("FAIL rnd_tag_err c=%0d got=%0d/%b exp=%0d/%b", c, out_tag, out_err, mq[0].tag, mq[0].err); end
         end
         total++; if (err_cnt !== 8'(sat(mcnt, 255)) || err_cnt_b !== 2'(sat(mcnt, 3))) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, err_cnt, err_cnt_b, sat(mcnt, 255), sat(mcnt, 3)); end
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_src    = 3'($urandom_range(0, 7));
         in_instr  = $urandom;
         in_tag    = 5'($urandom);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; in_src = 3'd7;
      for (int c = 0; c < 5 && mq.size() != 2; c++) begin
         in_tag = 5'($urandom); in_instr = $urandom;
         tick();
      end
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%b/%b exp=1/0", out_valid, in_ready); end
      total++; if (err_cnt !== 8'(sat(mcnt, 255))) begin bad++; $display("FAIL mid_cnt got=%0d exp=%0d", err_cnt, sat(mcnt, 255)); end
      rst = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || out_valid_b !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b/%b exp=0", out_valid, out_valid_b); end
      total++; if (err_cnt !== 8'd0 || err_cnt_b !== 2'd0) begin bad++; $display("FAIL mid_errcnt got=%0d/%0d exp=0", err_cnt, err_cnt_b); end
      total++; if (in_ready !== 1'b1 || in_ready_b !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b/%b exp=1", in_ready, in_ready_b); end
      @(negedge clk);
      in_valid = 1'b1; in_src = 3'd3; in_instr = 32'h80000037; in_tag = 5'd9;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_tag !== 5'd9) begin bad++; $display("FAIL mid_push got=%b/%0d exp=1/9", out_valid, out_tag); end
      total++; if (out_imm !== 32'h80000000 || out_imm_b !== 64'hFFFFFFFF80000000) begin bad++; $display("FAIL mid_imm got=%h/%h exp=80000000/ffffffff80000000", out_imm, out_imm_b); end
      tick();
   endtask

   initial begin
      total = 0; bad = 0; mcnt = 0;
      test_reset();
      test_formats();
      test_backpressure();
      test_illegal();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined immediate generator for all five RV32I immediate formats (I, S, B, U, J), parametrised in output width. It sits between the instruction-fetch/decode register and the execute stage. It replaces the I/S-only combinational sign extender with a registered stage behind a valid/ready handshake, a 2-entry output buffer, and illegal-format error reporting.

## Interface
Parameters:
- XLEN, 32: output immediate width; legal values 32 or 64.
- TAG_W, 5: width of a sideband tag (e.g. rd index or ROB id) carried alongside each instruction.
- CNT_W, 8: width of the saturating illegal-format counter.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_src  in  3  format select: 0=I, 1=S, 2=B, 3=U, 4=J, 5..7 illegal (absent when IMM_GEN_OPDEC_EN is defined).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the same entry.
- out_err  out  1  entry had an illegal format.
- err_cnt  out  CNT_W  saturating count of accepted illegal entries.

## Operation
- Extraction, with i = in_instr, all sign-extended from i[31] to XLEN:
  - I: i[31:20].
  - S: {i[31:25], i[11:7]}.
  - B: {i[31], i[7], i[30:25], i[11:8], 1'b0}.
  - U: {i[31:12], 12'b0}; bits XLEN-1..32 copy i[31].
  - J: {i[31], i[19:12], i[20], i[30:21], 1'b0}.
- Illegal format: imm = 0, err = 1.
- Handshake:
  - Push occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - Inputs are sampled only on a push. in_instr, in_src and in_tag may change freely at any other time.
- Buffer:
  - 2-entry FIFO of {imm, tag, err}, with the immediate computed before write. Order is preserved.
  - in_ready = (count != 2) && !rst. It is a function of registered count only, with no combinational path from out_ready.
  - out_valid = (count != 0). out_imm, out_tag and out_err show the head entry and are held stable while out_valid && !out_ready.
- Push and pop in the same cycle: count is unchanged. When count==1, the new entry becomes head after the pop.
- Full (count==2) with out_ready=1: the pop occurs, no push that cycle, and in_ready=1 the next cycle.
- err_cnt increments on every push whose format is illegal and saturates at 2^CNT_W-1. It is not decremented on pop.

## Timing
- Reset values: count=0, out_valid=0, out_imm=0, out_tag=0, out_err=0, err_cnt=0, in_ready=0 while rst=1 and 1 from the first cycle after.
- Latency: a push at edge k with the buffer empty gives out_valid=1 after edge k (visible in cycle k+1).
- Throughput: 1 entry/cycle with out_ready held high.
- Reset mid-operation: rst=1 at an edge discards all buffered entries and clears err_cnt. Any push or pop in that cycle is ignored.
- Head output is registered; out_imm has no combinational path from in_instr.

## Configuration
- IMM_GEN_OPDEC_EN undefined: the format comes from the in_src port.
- IMM_GEN_OPDEC_EN defined: the in_src port is removed and the format is decoded from in_instr[6:0]:
  - I: 0010011, 0000011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode is illegal (imm=0, err=1, err_cnt increments).

## Test plan
- XLEN=32, in_src=0, in_instr=0xFFF00093, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_err=0; then in_src=1, 0xFE112E23 -> 0xFFFFFFFC.
- in_src=2, 0xFE000EE3 -> 0xFFFFFFFC; in_src=3, 0x12345037 -> 0x12345000; in_src=4, 0x0000006F -> 0x00000000.
- Backpressure: out_ready=0 with three back-to-back pushes (tags 1,2,3) -> third is refused (in_ready=0), out_tag=1 held stable; raise out_ready -> tags 1,2,3 emerge in order with no loss or duplication.
- Illegal: in_src=7 pushed 3 times -> out_imm=0, out_err=1 each time, err_cnt=3; with CNT_W=2, 5 pushes -> err_cnt=3 (saturated).
- XLEN=64: in_src=0, 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF; in_src=3, 0x80000037 -> 0xFFFFFFFF80000000.
- Reset mid-stream: with 2 entries buffered, assert rst for 1 cycle -> out_valid=0, err_cnt=0, in_ready=1 the following cycle; with IMM_GEN_OPDEC_EN, 0x0000007F -> out_err=1.
